motor_step_ctrl: RTL and testbench

MOTOR_STEP_CTRL -- requirements
Module: motor_step_ctrl

---
 rtl/motor_pkg.sv | 28 ++
 rtl/step_timer.sv | 31 +++
 rtl/motor_step_ctrl.sv | 137 +++++++++++++
 tb/tb_motor_step_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and defaults for the stepper move controller.
package motor_pkg;

   typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} motor_state_e;

   localparam int PERIOD_W      = 20;
   localparam int START_DIV_DEF = 375000;
   localparam int MIN_DIV_DEF   = 125000;
   localparam int RAMP_STEP_DEF = 2500;

   // Saturating period adjust; widened by one bit so the sum/compare never wraps.
   function automatic logic [PERIOD_W-1:0] period_up(input logic [PERIOD_W-1:0] p,
                                                     input logic [PERIOD_W-1:0] inc,
                                                     input logic [PERIOD_W-1:0] ceil);
      logic [PERIOD_W:0] sum;
      sum = {1'b0, p} + {1'b0, inc};
      return (sum >= {1'b0, ceil}) ? ceil : sum[PERIOD_W-1:0];
   endfunction

   function automatic logic [PERIOD_W-1:0] period_down(input logic [PERIOD_W-1:0] p,
                                                       input logic [PERIOD_W-1:0] dec,
                                                       input logic [PERIOD_W-1:0] floor);
      logic [PERIOD_W:0] lim;
      lim = {1'b0, floor} + {1'b0, dec};
      return ({1'b0, p} >= lim) ? (p - dec) : floor;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Programmable period counter: counts 0..period-1 and strobes tick on the last count.
module step_timer
   import motor_pkg::*;
(
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [PERIOD_W-1:0] period,
   input  logic                clear,
   input  logic                enable,
   output logic                tick
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // >= keeps the counter from running away if period shrinks below the count
      tick  = enable && (cnt_q >= (period - PERIOD_W'(1)));
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/motor_step_ctrl.sv
// Trapezoidal-ramp half-step move controller driving a phase sequencer.
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ACCEL  | stepping, period shrinking toward MIN_DIV
// CRUISE | stepping at MIN_DIV
// DECEL  | stepping, period growing back toward START_DIV
// DONE   | one-cycle end-of-move strobe
module motor_step_ctrl
   import motor_pkg::*;
#(
   parameter int START_DIV = START_DIV_DEF,
   parameter int MIN_DIV   = MIN_DIV_DEF,
   parameter int RAMP_STEP = RAMP_STEP_DEF
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [15:0]        cmd_steps,
   input  logic               cmd_dir,
   input  logic               abort,
   output logic               mover,
   output logic               sentido,
   output logic               step,
   output logic               busy,
   output logic               done,
   output logic signed [31:0] pos
);

   localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_DIV);
   localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_DIV);
   localparam logic [PERIOD_W-1:0] RAMP_P  = PERIOD_W'(RAMP_STEP);

   motor_state_e        state_q, state_d;
   logic [15:0]         remaining_q, remaining_d;
   logic [15:0]         ramp_q, ramp_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic signed [31:0]  pos_q, pos_d;
   logic                sentido_q, sentido_d;
   logic [15:0]         rem_dec, ramp_inc, rem_abort;
   logic                tick, accept, moving;

   assign accept = (state_q == IDLE) && cmd_valid;
   assign moving = (state_q == ACCEL) || (state_q == CRUISE) || (state_q == DECEL);

   step_timer u_step_timer (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .period (period_q),
      .clear  (accept),
      .enable (moving),
      .tick   (tick)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         ramp_q      <= '0;
         period_q    <= '0;
         pos_q       <= '0;
         sentido_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         ramp_q      <= ramp_d;
         period_q    <= period_d;
         pos_q       <= pos_d;
         sentido_q   <= sentido_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      ramp_d      = ramp_q;
      period_d    = period_q;
      pos_d       = pos_q;
      sentido_d   = sentido_q;
      rem_dec     = remaining_q - 16'd1;
      ramp_inc    = (state_q == ACCEL) ? (ramp_q + 16'd1) : ramp_q;
      rem_abort   = '0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               sentido_d   = cmd_dir;
               remaining_d = cmd_steps;
               period_d    = START_P;
               ramp_d      = '0;
               state_d     = (cmd_steps == 16'd0) ? DONE : ACCEL;
            end
         end
         ACCEL, CRUISE, DECEL: begin
            if (tick) begin
               remaining_d = rem_dec;
               ramp_d      = ramp_inc;
               pos_d       = sentido_q ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
               if (rem_dec == 16'd0) begin
                  state_d = DONE;
               end else if (state_q == DECEL) begin
                  period_d = period_up(period_q, RAMP_P, START_P);
               end else if (rem_dec <= ramp_inc) begin
                  state_d  = DECEL;
                  period_d = period_up(period_q, RAMP_P, START_P);
               end else if (state_q == ACCEL) begin
                  period_d = period_down(period_q, RAMP_P, MIN_P);
                  if (period_d == MIN_P) state_d = CRUISE;
               end
            end
            // Abort acts on the post-step values; with nothing left to ramp down, stop outright.
            if (abort && ((state_d == ACCEL) || (state_d == CRUISE))) begin
               rem_abort   = (remaining_d < ramp_d) ? remaining_d : ramp_d;
               remaining_d = rem_abort;
               if (rem_abort == 16'd0) begin
                  state_d = DONE;
               end else begin
                  state_d  = DECEL;
                  period_d = period_up(period_d, RAMP_P, START_P);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE);
      mover     = moving;
      busy      = moving;
      step      = tick;
      done      = (state_q == DONE);
      sentido   = sentido_q;
      pos       = pos_q;
   end

endmodule

// File: tb/tb_motor_step_ctrl.sv
// Directed bench for motor_step_ctrl with short ramp parameters (10/4/2).
module tb_motor_step_ctrl;

   logic               CLK = 1'b0;
   logic               RST_N;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [15:0]        cmd_steps;
   logic               cmd_dir;
   logic               abort;
   logic               mover;
   logic               sentido;
   logic               step;
   logic               busy;
   logic               done;
   logic signed [31:0] pos;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rv_cnt = 0;
   int rv_cyc = 0;
   int acc_cyc = 0;
   int done_base = 0;
   int rv0 = 0;
   int d0 = 0;
   int step_times[$];
   int exp_iv[$];

   always #5 CLK = ~CLK;

   motor_step_ctrl #(.START_DIV(10), .MIN_DIV(4), .RAMP_STEP(2)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_steps (cmd_steps),
      .cmd_dir   (cmd_dir),
      .abort     (abort),
      .mover     (mover),
      .sentido   (sentido),
      .step      (step),
      .busy      (busy),
      .done      (done),
      .pos       (pos)
   );

   // Inputs change at negedge+1, so the negedge view is stable for the whole cycle.
   always @(negedge CLK) begin
      if (step) step_times.push_back(cyc);
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (cmd_valid && cmd_ready) begin
         rv_cnt <= rv_cnt + 1;
         rv_cyc <= cyc;
      end
      cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick1();
      @(negedge CLK);
      #1;
   endtask

   task automatic start_cmd(input int n, input bit d, input bit hold);
      step_times.delete();
      cmd_steps = 16'(n);
      cmd_dir   = d;
      cmd_valid = 1'b1;
      check_eq("ready_in_idle", cmd_ready, 1);
      acc_cyc   = cyc - 1;
      done_base = done_cnt;
      tick1();
      if (!hold) cmd_valid = 1'b0;
      check_eq("busy_after_accept", busy, (n != 0) ? 1 : 0);
      check_eq("mover_after_accept", mover, (n != 0) ? 1 : 0);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000 && done_cnt == done_base; i++) tick1();
      check_eq({tag, "_done_high"}, done, 1);
      check_eq({tag, "_mover_at_done"}, mover, 0);
      check_eq({tag, "_busy_at_done"}, busy, 0);
      tick1();
      check_eq({tag, "_done_one_cycle"}, done, 0);
      check_eq({tag, "_ready_after"}, cmd_ready, 1);
      check_eq({tag, "_done_count"}, done_cnt - done_base, 1);
   endtask

   task automatic check_ivs(input string tag);
      int prev;
      prev = acc_cyc;
      check_eq({tag, "_nsteps"}, step_times.size(), exp_iv.size());
      for (int i = 0; i < step_times.size() && i < exp_iv.size(); i++) begin
         check_eq($sformatf("%s_iv%0d", tag, i), step_times[i] - prev, exp_iv[i]);
         prev = step_times[i];
      end
   endtask

   initial begin
      RST_N     = 1'b0;
      cmd_valid = 1'b0;
      cmd_steps = '0;
      cmd_dir   = 1'b0;
      abort     = 1'b0;
      tick1();
      tick1();
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_mover", mover, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_step", step, 0);
      check_eq("rst_pos", pos, 0);
      check_eq("rst_sentido", sentido, 1);
      RST_N = 1'b1;
      tick1();
      tick1();

      exp_iv = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
      start_cmd(10, 1'b1, 1'b0);
      wait_done("fwd10");
      check_ivs("fwd10");
      check_eq("fwd10_pos", pos, 10);
      check_eq("fwd10_sentido", sentido, 1);

      exp_iv = '{10, 8, 10, 10};
      start_cmd(4, 1'b0, 1'b0);
      wait_done("rev4");
      check_ivs("rev4");
      check_eq("rev4_pos", pos, 6);
      check_eq("rev4_sentido", sentido, 0);

      exp_iv.delete();
      start_cmd(0, 1'b1, 1'b0);
      wait_done("zero");
      check_ivs("zero");
      check_eq("zero_done_latency", done_cyc - acc_cyc, 1);
      check_eq("zero_pos", pos, 6);

      abort = 1'b1;
      tick1();
      tick1();
      check_eq("idle_abort_ready", cmd_ready, 1);
      check_eq("idle_abort_busy", busy, 0);
      abort = 1'b0;

      exp_iv = '{10, 8, 6, 4, 4, 6, 8, 10};
      start_cmd(100, 1'b1, 1'b0);
      for (int i = 0; i < 500 && step_times.size() < 5; i++) tick1();
      check_eq("abort_reached_step5", step_times.size(), 5);
      tick1();
      abort = 1'b1;
      tick1();
      abort = 1'b0;
      wait_done("abort");
      check_ivs("abort");
      check_eq("abort_pos", pos, 14);

      exp_iv = '{10, 10};
      rv0 = rv_cnt;
      start_cmd(2, 1'b1, 1'b1);
      wait_done("hold1");
      check_ivs("hold1");
      check_eq("hold1_pos", pos, 16);
      check_eq("hold_single_accept", rv_cnt - rv0, 1);
      check_eq("hold_accept_cycle", rv_cyc - done_cyc, 1);
      step_times.delete();
      acc_cyc   = cyc - 1;
      done_base = done_cnt;
      tick1();
      cmd_valid = 1'b0;
      check_eq("hold2_busy", busy, 1);
      wait_done("hold2");
      check_ivs("hold2");
      check_eq("hold2_pos", pos, 18);

      start_cmd(100, 1'b1, 1'b0);
      for (int i = 0; i < 500 && step_times.size() < 4; i++) tick1();
      tick1();
      check_eq("pre_rst_mover", mover, 1);
      RST_N = 1'b0;
      #1;
      check_eq("async_rst_mover", mover, 0);
      check_eq("async_rst_pos", pos, 0);
      check_eq("async_rst_ready", cmd_ready, 1);
      check_eq("async_rst_busy", busy, 0);
      d0 = done_cnt;
      tick1();
      tick1();
      tick1();
      check_eq("rst_no_done", done_cnt - d0, 0);
      RST_N = 1'b1;
      tick1();
      check_eq("post_rst_sentido", sentido, 1);
      check_eq("post_rst_ready", cmd_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
